// File: rtl/boot_sequencer.sv
// boot_sequencer: start-up controller for the pulpino_top SoC.
// Settles after reset, optionally waits for the SPI image load, writes the
// boot address to the SoC config register, enables fetch, then watches the
// end-of-computation flag and reports pass/fail/error.
// Optional RUN-state watchdog: define BOOT_SEQUENCER_WDT_EN.
`timescale 1ns/1ps
module boot_sequencer #(
   parameter int unsigned SETTLE_CYCLES = 13,
   parameter logic [31:0] CFG_ADDR      = 32'h1A10_7008
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  boot_mode_i,
   input  logic        load_done_i,
   input  logic [31:0] boot_addr_i,
   output logic        cfg_req_o,
   output logic [31:0] cfg_addr_o,
   output logic [31:0] cfg_wdata_o,
   input  logic        cfg_gnt_i,
   input  logic        cfg_err_i,
   input  logic        eoc_i,
   input  logic [31:0] exit_code_i,
   input  logic        restart_i,
   input  logic [31:0] wdt_limit_i,
   output logic        fetch_enable_o,
   output logic        done_o,
   output logic [1:0]  status_o,
   output logic [31:0] exit_code_o,
   output logic [2:0]  state_o
);

   typedef enum logic [2:0] {
      SETTLE    = 3'd0,
      LOAD_WAIT = 3'd1,
      CFG_WRITE = 3'd2,
      START     = 3'd3,
      RUN       = 3'd4,
      DONE      = 3'd5,
      ERROR     = 3'd6
   } state_e;

   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

   state_e      state_q, state_d;
   logic [7:0]  settle_cnt_q, settle_cnt_d;
   logic        cfg_req_q, cfg_req_d;
   logic [31:0] cfg_wdata_q, cfg_wdata_d;
   logic        fetch_enable_q, fetch_enable_d;
   logic [1:0]  status_q, status_d;
   logic [31:0] exit_code_q, exit_code_d;
   logic        wdt_expired;

`ifdef BOOT_SEQUENCER_WDT_EN
   logic [31:0] wdt_cnt_q, wdt_cnt_d;

   // Watchdog: wdt_cnt_d is the number of RUN cycles including the current one;
   // held at zero outside RUN so it restarts on every RUN entry.
   always_comb begin
      wdt_cnt_d   = '0;
      wdt_expired = 1'b0;
      if (state_q == RUN) begin
         wdt_cnt_d   = wdt_cnt_q + 32'd1;
         wdt_expired = (wdt_limit_i != '0) && (wdt_cnt_d == wdt_limit_i);
      end
   end

   // Watchdog counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) wdt_cnt_q <= '0;
      else        wdt_cnt_q <= wdt_cnt_d;
   end
`else
   logic unused_wdt_limit;
   assign unused_wdt_limit = ^wdt_limit_i;
   assign wdt_expired      = 1'b0;
`endif

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= SETTLE;
         settle_cnt_q   <= '0;
         cfg_req_q      <= 1'b0;
         cfg_wdata_q    <= '0;
         fetch_enable_q <= 1'b0;
         status_q       <= '0;
         exit_code_q    <= '0;
      end else begin
         state_q        <= state_d;
         settle_cnt_q   <= settle_cnt_d;
         cfg_req_q      <= cfg_req_d;
         cfg_wdata_q    <= cfg_wdata_d;
         fetch_enable_q <= fetch_enable_d;
         status_q       <= status_d;
         exit_code_q    <= exit_code_d;
      end
   end

   // Next-state selection
   always_comb begin
      state_d = state_q;
      case (state_q)
         SETTLE: begin
            if (settle_cnt_q == SETTLE_LAST) begin
               case (boot_mode_i)
                  2'b00:   state_d = CFG_WRITE;
                  2'b01:   state_d = LOAD_WAIT;
                  2'b10:   state_d = START;
                  default: state_d = ERROR;
               endcase
            end
         end
         LOAD_WAIT: if (load_done_i) state_d = CFG_WRITE;
         CFG_WRITE: if (cfg_gnt_i) state_d = cfg_err_i ? ERROR : START;
         START:     state_d = RUN;
         RUN: begin
            if (eoc_i)            state_d = DONE;
            else if (wdt_expired) state_d = ERROR;
         end
         DONE, ERROR: if (restart_i) state_d = SETTLE;
         default:     state_d = SETTLE;
      endcase
   end

   // Registered outputs, computed from the transition being taken
   always_comb begin
      settle_cnt_d   = '0;
      cfg_req_d      = (state_d == CFG_WRITE);
      cfg_wdata_d    = cfg_wdata_q;
      fetch_enable_d = fetch_enable_q;
      status_d       = status_q;
      exit_code_d    = exit_code_q;

      if (state_q == SETTLE && state_d == SETTLE)
         settle_cnt_d = settle_cnt_q + 8'd1;

      if (state_d == CFG_WRITE && state_q != CFG_WRITE)
         cfg_wdata_d = boot_addr_i;

      if (state_q == START)
         fetch_enable_d = 1'b1;
      if (state_d == DONE || state_d == ERROR)
         fetch_enable_d = 1'b0;

      if (state_q == RUN && state_d == DONE) begin
         exit_code_d = exit_code_i;
         status_d    = (exit_code_i == '0) ? 2'b01 : 2'b10;
      end

      if (state_d == ERROR && state_q != ERROR)
         status_d = 2'b11;

      if ((state_q == DONE || state_q == ERROR) && state_d == SETTLE) begin
         status_d    = 2'b00;
         exit_code_d = '0;
      end
   end

   assign cfg_req_o      = cfg_req_q;
   assign cfg_addr_o     = cfg_req_q ? CFG_ADDR : '0;
   assign cfg_wdata_o    = cfg_wdata_q;
   assign fetch_enable_o = fetch_enable_q;
   assign done_o         = (state_q == DONE) || (state_q == ERROR);
   assign status_o       = status_q;
   assign exit_code_o    = exit_code_q;
   assign state_o        = state_q;

endmodule

// File: tb/tb_boot_sequencer.sv
// Directed bench for boot_sequencer with a scoreboard of expected
// cfg write data / status / exit code values.
`timescale 1ns/1ps
module tb_boot_sequencer;

   localparam int unsigned SETTLE = 13;
   localparam logic [31:0] CADDR  = 32'h1A10_7008;

   logic        clk, rst_n;
   logic [1:0]  boot_mode_i;
   logic        load_done_i;
   logic [31:0] boot_addr_i;
   logic        cfg_req_o;
   logic [31:0] cfg_addr_o, cfg_wdata_o;
   logic        cfg_gnt_i, cfg_err_i, eoc_i, restart_i;
   logic [31:0] exit_code_i, wdt_limit_i;
   logic        fetch_enable_o, done_o;
   logic [1:0]  status_o;
   logic [31:0] exit_code_o;
   logic [2:0]  state_o;

   boot_sequencer #(.SETTLE_CYCLES(SETTLE), .CFG_ADDR(CADDR)) dut (
      .clk(clk), .rst_n(rst_n), .boot_mode_i(boot_mode_i), .load_done_i(load_done_i),
      .boot_addr_i(boot_addr_i), .cfg_req_o(cfg_req_o), .cfg_addr_o(cfg_addr_o),
      .cfg_wdata_o(cfg_wdata_o), .cfg_gnt_i(cfg_gnt_i), .cfg_err_i(cfg_err_i),
      .eoc_i(eoc_i), .exit_code_i(exit_code_i), .restart_i(restart_i),
      .wdt_limit_i(wdt_limit_i), .fetch_enable_o(fetch_enable_o), .done_o(done_o),
      .status_o(status_o), .exit_code_o(exit_code_o), .state_o(state_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   logic [31:0] sb_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic sb_chk(input string tag, input logic [31:0] obs);
      logic [31:0] e;
      if (sb_q.size() == 0) begin
         total++;
         bad++;
         $error("FAIL %s observed=%0h expected=<scoreboard empty>", tag, obs);
      end else begin
         e = sb_q.pop_front();
         chk(tag, obs, e);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // n counts cycles from `start`; stops when cfg_req_o seen or budget spent
   task automatic wait_req(input int start, input int max, output int n);
      n = start;
      while (cfg_req_o !== 1'b1 && n < max) begin
         tick();
         n++;
      end
   endtask

   task automatic wait_state(input logic [2:0] s, input int max, output int n);
      n = 0;
      while (state_o !== s && n < max) begin
         tick();
         n++;
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_state"}, 32'(state_o), 32'd0);
      chk({tag, "_req"}, 32'(cfg_req_o), 32'd0);
      chk({tag, "_addr"}, cfg_addr_o, 32'd0);
      chk({tag, "_fetch"}, 32'(fetch_enable_o), 32'd0);
      chk({tag, "_done"}, 32'(done_o), 32'd0);
      chk({tag, "_status"}, 32'(status_o), 32'd0);
      chk({tag, "_exit"}, exit_code_o, 32'd0);
   endtask

   initial begin
      int n;
      int run_cycles;
      logic req_seen, fetch_seen;

      rst_n = 1'b0; boot_mode_i = 2'b00; load_done_i = 1'b0; boot_addr_i = '0;
      cfg_gnt_i = 1'b0; cfg_err_i = 1'b0; eoc_i = 1'b0; exit_code_i = '0;
      restart_i = 1'b0; wdt_limit_i = 32'd100;
      repeat (2) tick();
      chk_idle_outputs("reset");
      chk("reset_wdata", cfg_wdata_o, 32'd0);

      // PRELOAD, boot address 0, gnt one cycle after req
      sb_q.push_back(32'h0000_0000);
      rst_n = 1'b1;
      wait_req(1, 60, n);
      chk("pre_req_latency", 32'(n), 32'(SETTLE + 1));
      chk("pre_state_cfg", 32'(state_o), 32'd2);
      chk("pre_addr", cfg_addr_o, CADDR);
      sb_chk("pre_wdata", cfg_wdata_o);
      tick();
      chk("pre_req_hold", 32'(cfg_req_o), 32'd1);
      cfg_gnt_i = 1'b1;
      tick();
      cfg_gnt_i = 1'b0;
      chk("pre_state_start", 32'(state_o), 32'd3);
      chk("pre_req_drop", 32'(cfg_req_o), 32'd0);
      chk("pre_fetch_n1", 32'(fetch_enable_o), 32'd0);
      tick();
      chk("pre_state_run", 32'(state_o), 32'd4);
      chk("pre_fetch_n2", 32'(fetch_enable_o), 32'd1);

      // restart ignored outside DONE/ERROR
      restart_i = 1'b1;
      tick();
      restart_i = 1'b0;
      chk("run_restart_ignored", 32'(state_o), 32'd4);

      // eoc with exit code 0 -> pass
      exit_code_i = 32'd0;
      sb_q.push_back(32'd1);
      sb_q.push_back(32'd0);
      eoc_i = 1'b1;
      tick();
      eoc_i = 1'b0;
      sb_chk("pass_status", 32'(status_o));
      sb_chk("pass_exit", exit_code_o);
      chk("pass_done", 32'(done_o), 32'd1);
      chk("pass_fetch", 32'(fetch_enable_o), 32'd0);
      chk("pass_state", 32'(state_o), 32'd5);

      // restart into SPI mode
      boot_mode_i = 2'b01;
      restart_i = 1'b1;
      tick();
      restart_i = 1'b0;
      chk_idle_outputs("restart");
      wait_state(3'd1, 60, n);
      chk("spi_settle_len", 32'(n), 32'(SETTLE));
      boot_mode_i = 2'b11;
      repeat (200) tick();
      chk("spi_wait_state", 32'(state_o), 32'd1);
      chk("spi_wait_req", 32'(cfg_req_o), 32'd0);
      boot_addr_i = 32'hDEAD_BEEF;
      sb_q.push_back(32'hDEAD_BEEF);
      load_done_i = 1'b1;
      tick();
      load_done_i = 1'b0;
      chk("spi_req_rise", 32'(cfg_req_o), 32'd1);
      sb_chk("spi_wdata", cfg_wdata_o);
      boot_addr_i = 32'h1234_5678;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("spi_req_held", 32'(cfg_req_o), 32'd1);
         chk("spi_addr_stable", cfg_addr_o, CADDR);
         chk("spi_wdata_stable", cfg_wdata_o, 32'hDEAD_BEEF);
         chk("spi_no_fetch", 32'(fetch_enable_o), 32'd0);
      end
      cfg_gnt_i = 1'b1;
      tick();
      cfg_gnt_i = 1'b0;
      chk("spi_req_drop", 32'(cfg_req_o), 32'd0);
      chk("spi_fetch_n1", 32'(fetch_enable_o), 32'd0);
      tick();
      chk("spi_fetch_n2", 32'(fetch_enable_o), 32'd1);

      // eoc with exit code 5 -> fail
      exit_code_i = 32'd5;
      sb_q.push_back(32'd2);
      sb_q.push_back(32'd5);
      eoc_i = 1'b1;
      tick();
      eoc_i = 1'b0;
      exit_code_i = 32'h0000_FFFF;
      sb_chk("fail_status", 32'(status_o));
      sb_chk("fail_exit", exit_code_o);
      chk("fail_done", 32'(done_o), 32'd1);
      tick();
      chk("fail_exit_latched", exit_code_o, 32'd5);

      // reset from DONE, then STANDALONE boot
      #3 rst_n = 1'b0;
      #1 chk_idle_outputs("rst_done");
      boot_mode_i = 2'b10;
      tick();
      rst_n = 1'b1;
      n = 1;
      req_seen = 1'b0;
      while (fetch_enable_o !== 1'b1 && n < 60) begin
         tick();
         n++;
         if (cfg_req_o === 1'b1) req_seen = 1'b1;
      end
      chk("sa_fetch_latency", 32'(n), 32'(SETTLE + 2));
      chk("sa_no_req", 32'(req_seen), 32'd0);

`ifdef BOOT_SEQUENCER_WDT_EN
      run_cycles = 1;
      while (state_o === 3'd4 && run_cycles < 300) begin
         tick();
         run_cycles++;
      end
      chk("wdt_run_cycles", 32'(run_cycles - 1), 32'd100);
      chk("wdt_state", 32'(state_o), 32'd6);
      chk("wdt_status", 32'(status_o), 32'd3);
      chk("wdt_fetch", 32'(fetch_enable_o), 32'd0);
      wdt_limit_i = 32'd0;
      restart_i = 1'b1;
      tick();
      restart_i = 1'b0;
      wait_state(3'd4, 60, n);
      chk("wdt0_run", 32'(state_o), 32'd4);
`endif
      repeat (150) tick();
      chk("run_no_timeout", 32'(state_o), 32'd4);
      chk("run_fetch_high", 32'(fetch_enable_o), 32'd1);

      // reset mid-RUN
      #3 rst_n = 1'b0;
      #1 chk_idle_outputs("rst_run");

      // reset mid-handshake; a gnt arriving after reset must be ignored
      boot_mode_i = 2'b00;
      boot_addr_i = 32'hA5A5_0000;
      sb_q.push_back(32'hA5A5_0000);
      tick();
      rst_n = 1'b1;
      wait_req(1, 60, n);
      chk("hs_req_latency", 32'(n), 32'(SETTLE + 1));
      sb_chk("hs_wdata", cfg_wdata_o);
      #3 rst_n = 1'b0;
      #1 chk("hs_req_async_drop", 32'(cfg_req_o), 32'd0);
      chk("hs_addr_drop", cfg_addr_o, 32'd0);
      cfg_gnt_i = 1'b1;
      tick();
      rst_n = 1'b1;
      tick();
      tick();
      cfg_gnt_i = 1'b0;
      chk("hs_gnt_ignored", 32'(state_o), 32'd0);

      // gnt with error
      wait_req(3, 60, n);
      chk("err_req_latency", 32'(n), 32'(SETTLE + 1));
      cfg_gnt_i = 1'b1;
      cfg_err_i = 1'b1;
      tick();
      cfg_gnt_i = 1'b0;
      cfg_err_i = 1'b0;
      chk("err_state", 32'(state_o), 32'd6);
      chk("err_status", 32'(status_o), 32'd3);
      chk("err_done", 32'(done_o), 32'd1);
      chk("err_fetch", 32'(fetch_enable_o), 32'd0);
      chk("err_exit", exit_code_o, 32'd0);

      // illegal boot mode
      boot_mode_i = 2'b11;
      restart_i = 1'b1;
      tick();
      restart_i = 1'b0;
      chk("ill_status_clr", 32'(status_o), 32'd0);
      n = 0;
      fetch_seen = 1'b0;
      req_seen = 1'b0;
      while (state_o !== 3'd6 && n < 60) begin
         tick();
         n++;
         if (fetch_enable_o === 1'b1) fetch_seen = 1'b1;
         if (cfg_req_o === 1'b1) req_seen = 1'b1;
      end
      chk("ill_settle_len", 32'(n), 32'(SETTLE));
      chk("ill_status", 32'(status_o), 32'd3);
      chk("ill_no_fetch", 32'(fetch_seen), 32'd0);
      chk("ill_no_req", 32'(req_seen), 32'd0);

      // eoc already high on RUN entry completes after one RUN cycle
      boot_mode_i = 2'b10;
      eoc_i = 1'b1;
      exit_code_i = 32'd0;
      restart_i = 1'b1;
      tick();
      restart_i = 1'b0;
      wait_state(3'd4, 60, n);
      run_cycles = 0;
      while (state_o === 3'd4 && run_cycles < 10) begin
         tick();
         run_cycles++;
      end
      eoc_i = 1'b0;
      chk("eoc_early_run_len", 32'(run_cycles), 32'd1);
      chk("eoc_early_state", 32'(state_o), 32'd5);
      chk("eoc_early_status", 32'(status_o), 32'd1);

      chk("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/boot_sequencer.md
# boot_sequencer

Start-up controller for the pulpino_top SoC. After reset it waits a settle time and, in SPI mode, waits for the SPI-slave image load to finish. It then writes the boot address into the SoC configuration register and raises fetch_enable. It watches the end-of-computation flag (GPIO 8), latches the program exit code, and reports pass/fail/error.

## Interface
- SETTLE_CYCLES, 13: cycles held in SETTLE after reset release (≈500 ns at 25 MHz); legal range 1..255.
- CFG_ADDR, 32'h1A10_7008: configuration-bus address of the boot-address register.
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- boot_mode_i  in  2  boot mode: 00 PRELOAD, 01 SPI, 10 STANDALONE, 11 illegal.
- load_done_i  in  1  SPI-slave load complete, level; sampled only in LOAD_WAIT.
- boot_addr_i  in  32  value written to CFG_ADDR.
- cfg_req_o  out  1  configuration write request.
- cfg_addr_o  out  32  write address; equals CFG_ADDR whenever cfg_req_o=1, otherwise 0.
- cfg_wdata_o  out  32  write data; equals boot_addr_i, registered on entry to CFG_WRITE.
- cfg_gnt_i  in  1  single-cycle write acknowledge.
- cfg_err_i  in  1  write error; valid only together with cfg_gnt_i.
- eoc_i  in  1  end-of-computation level (gpio_out[8]); synchronous to clk.
- exit_code_i  in  32  program return code; sampled when eoc is accepted.
- restart_i  in  1  re-run request; honoured only in DONE or ERROR.
- wdt_limit_i  in  32  RUN-state timeout in cycles; 0 disables the timeout.
- fetch_enable_o  out  1  core fetch enable.
- done_o  out  1  high in DONE and in ERROR.
- status_o  out  2  00 busy, 01 pass, 10 fail, 11 error.
- exit_code_o  out  32  latched exit code.
- state_o  out  3  current state encoding, for debug.

## Operation
States and encodings: SETTLE 0, LOAD_WAIT 1, CFG_WRITE 2, START 3, RUN 4, DONE 5, ERROR 6.

- SETTLE: counter runs from 0. At count SETTLE_CYCLES-1 the next state is chosen by boot_mode_i:
  - 00 → CFG_WRITE
  - 01 → LOAD_WAIT
  - 10 → START (no config write)
  - 11 → ERROR
- LOAD_WAIT: load_done_i=1 → CFG_WRITE. There is no timeout here.
- CFG_WRITE: cfg_req_o held high and address/data held stable until cfg_gnt_i.
  - gnt with err=0 → START.
  - gnt with err=1 → ERROR.
  - cfg_req_o drops in the cycle after gnt.
- START: fetch_enable_o set → RUN. This is one cycle.
- RUN: eoc_i=1 → DONE, and exit_code_o ← exit_code_i. eoc is level-sensitive, so eoc already high on entry to RUN completes immediately.
- DONE: fetch_enable_o cleared. status_o = 01 if the latched code is 0, else 10.
- ERROR: fetch_enable_o cleared, status_o = 11, exit_code_o unchanged.
- restart_i in DONE or ERROR → SETTLE:
  - status_o ← 00, exit_code_o ← 0, settle counter cleared.
  - restart_i is ignored in every other state.
- Reset (any time, including mid-RUN or mid-handshake):
  - all outputs 0, state SETTLE.
  - cfg_req_o drops asynchronously; an outstanding gnt after reset is ignored.
- boot_mode_i is sampled only on leaving SETTLE; later changes are ignored until the next restart or reset.

## Timing
- All outputs are registered; no combinational input→output paths.
- First cfg_req_o=1 occurs SETTLE_CYCLES+1 cycles after rst_n rises (PRELOAD mode).
- In LOAD_WAIT, cfg_req_o rises the cycle after load_done_i is seen.
- gnt in cycle N → fetch_enable_o=1 in cycle N+2: START is entered at N+1 and fetch_enable_o registers from START.
- eoc_i seen in cycle N → done_o, status_o, exit_code_o valid in cycle N+1; fetch_enable_o low in N+1.
- status_o changes only on entry to DONE, on entry to ERROR, or on restart.

## Configuration
- BOOT_SEQUENCER_WDT_EN defined:
  - A 32-bit cycle counter clears on entry to RUN and increments every RUN cycle.
  - When the counter equals wdt_limit_i (nonzero) and eoc_i=0 → ERROR.
  - If eoc_i=1 in the same cycle, eoc wins (DONE).
  - wdt_limit_i=0 never times out.
- Undefined: the counter is not built, wdt_limit_i is ignored, and RUN waits indefinitely.

## Test plan
- PRELOAD, boot_addr_i=32'h0000_0000, gnt one cycle after req → cfg write of 0 to 32'h1A10_7008; fetch_enable_o rises 2 cycles after gnt; state sequence 0,2,3,4.
- SPI mode, load_done_i raised 200 cycles after settle, gnt delayed 5 cycles → req held 6 cycles with stable addr/data; fetch_enable_o only after gnt.
- STANDALONE → no cfg_req_o ever; fetch_enable_o=1 at SETTLE_CYCLES+2 after reset release.
- RUN, eoc_i=1 with exit_code_i=0 → status 01, done_o=1; on restart, eoc with exit_code_i=32'h0000_0005 → status 10, exit_code_o=5.
- gnt with cfg_err_i=1, and separately boot_mode_i=11 → ERROR, status 11, fetch_enable_o never set.
- WDT_EN, wdt_limit_i=100, eoc_i held low → ERROR after 100 RUN cycles; rst_n pulsed low mid-RUN → all outputs 0 immediately, sequence restarts.
